// File: rtl/usb_rx_frontend.sv
// rtl/usb_rx_frontend.sv - USB receive front end: line sync, bit recovery, NRZI decode, unstuffing, SYNC/EOP framing
// Optional first-byte PID check enabled by defining USB_RX_PID_CHECK_EN.
module usb_rx_frontend #(
    parameter int CLK_PER_BIT = 8,
    parameter int LOW_SPEED   = 1,
    parameter int IDLE_BITS   = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       USB_DP,
    input  logic       USB_DM,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_pkt_start,
    output logic       rx_pkt_end,
    output logic       rx_err,
    output logic       rx_active
);
    localparam int PW = $clog2(CLK_PER_BIT);
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_PER_BIT - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(CLK_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);

    typedef enum logic [1:0] {LS_SE0 = 2'b00, LS_J = 2'b01, LS_K = 2'b10, LS_SE1 = 2'b11} line_t;
    typedef enum logic [2:0] {ST_WAIT_IDLE, ST_IDLE, ST_SYNC, ST_DATA, ST_EOP} state_t;

    logic          r_dp_s1, r_dp_s2, r_dm_s1, r_dm_s2;
    line_t         w_ls, r_ls_prev, r_nrzi_prev, w_nrzi_nxt;
    logic [PW-1:0] r_phase;
    logic          w_ls_change, w_sample, w_bit, w_fail;
    logic [7:0]    w_byte;
    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_idle_cnt, w_idle_cnt_nxt;
    logic [2:0]    r_sync_cnt, w_sync_cnt_nxt;
    logic [2:0]    r_ones, w_ones_nxt;
    logic [2:0]    r_bcnt, w_bcnt_nxt;
    logic [1:0]    r_se0_cnt, w_se0_cnt_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_data, w_data_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_start, w_start_nxt;
    logic          r_end, w_end_nxt;
    logic          r_err, w_err_nxt;
    logic          r_active, w_active_nxt;
`ifdef USB_RX_PID_CHECK_EN
    logic          r_first, w_first_nxt;
`endif

    always_comb begin
        case ({r_dp_s2, r_dm_s2})
            2'b00:   w_ls = LS_SE0;
            2'b11:   w_ls = LS_SE1;
            2'b01:   w_ls = (LOW_SPEED != 0) ? LS_J : LS_K;
            default: w_ls = (LOW_SPEED != 0) ? LS_K : LS_J;
        endcase
    end

    // Phase realigns on every edge so the sample sits mid-bit despite edge jitter
    assign w_ls_change = (w_ls != r_ls_prev);
    assign w_sample    = (r_phase == PH_SAMPLE);
    assign w_bit       = (w_ls == r_nrzi_prev);
    assign w_byte      = {w_bit, r_shift[7:1]};

    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = r_idle_cnt;
        w_sync_cnt_nxt = r_sync_cnt;
        w_ones_nxt     = r_ones;
        w_bcnt_nxt     = r_bcnt;
        w_se0_cnt_nxt  = r_se0_cnt;
        w_shift_nxt    = r_shift;
        w_data_nxt     = r_data;
        w_nrzi_nxt     = r_nrzi_prev;
        w_valid_nxt    = 1'b0;
        w_start_nxt    = 1'b0;
        w_end_nxt      = 1'b0;
        w_err_nxt      = 1'b0;
        w_active_nxt   = r_active;
        w_fail         = 1'b0;
`ifdef USB_RX_PID_CHECK_EN
        w_first_nxt    = r_first;
`endif
        case (r_state)
            ST_WAIT_IDLE: begin
                if (w_sample) begin
                    if (w_ls != LS_J) begin
                        w_idle_cnt_nxt = '0;
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        w_idle_cnt_nxt = '0;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (r_ls_prev == LS_J && w_ls == LS_K) begin
                    w_state_nxt    = ST_SYNC;
                    w_nrzi_nxt     = LS_J;
                    w_sync_cnt_nxt = 3'd0;
                end
            end
            ST_SYNC: begin
                if (w_sample) begin
                    w_nrzi_nxt     = w_ls;
                    w_sync_cnt_nxt = r_sync_cnt + 3'd1;
                    if (w_ls == LS_SE0 || w_ls == LS_SE1 ||
                        (r_sync_cnt == 3'd7 && !(w_ls == LS_K && r_nrzi_prev == LS_K))) begin
                        w_state_nxt    = ST_WAIT_IDLE;
                        w_idle_cnt_nxt = '0;
                    end else if (w_ls == LS_K && r_nrzi_prev == LS_K) begin
                        w_state_nxt  = ST_DATA;
                        w_start_nxt  = 1'b1;
                        w_active_nxt = 1'b1;
                        w_ones_nxt   = 3'd0;
                        w_bcnt_nxt   = 3'd0;
`ifdef USB_RX_PID_CHECK_EN
                        w_first_nxt  = 1'b1;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (w_sample) begin
                    if (w_ls == LS_SE0) begin
                        if (r_bcnt != 3'd0) begin
                            w_fail = 1'b1;
                        end else begin
                            w_state_nxt   = ST_EOP;
                            w_se0_cnt_nxt = 2'd1;
                        end
                    end else if (w_ls == LS_SE1) begin
                        w_fail = 1'b1;
                    end else begin
                        w_nrzi_nxt = w_ls;
                        if (r_ones == 3'd6) begin
                            // Stuffed position: a 0 is dropped, a 1 is a stuff error
                            if (w_bit) w_fail = 1'b1;
                            else       w_ones_nxt = 3'd0;
                        end else begin
                            w_ones_nxt  = w_bit ? r_ones + 3'd1 : 3'd0;
                            w_shift_nxt = w_byte;
                            w_bcnt_nxt  = r_bcnt + 3'd1;
                            if (r_bcnt == 3'd7) begin
                                w_data_nxt  = w_byte;
                                w_valid_nxt = 1'b1;
`ifdef USB_RX_PID_CHECK_EN
                                if (r_first && (w_byte[7:4] != ~w_byte[3:0])) w_fail = 1'b1;
                                w_first_nxt = 1'b0;
`endif
                            end
                        end
                    end
                end
            end
            ST_EOP: begin
                if (w_sample) begin
                    if (w_ls == LS_SE0) begin
                        if (r_se0_cnt == 2'd2) w_fail = 1'b1;
                        else                   w_se0_cnt_nxt = r_se0_cnt + 2'd1;
                    end else if (w_ls == LS_J) begin
                        w_end_nxt    = 1'b1;
                        w_active_nxt = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_WAIT_IDLE;
        endcase
        if (w_fail) begin
            w_err_nxt      = 1'b1;
            w_active_nxt   = 1'b0;
            w_state_nxt    = ST_WAIT_IDLE;
            w_idle_cnt_nxt = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dp_s1     <= 1'b0;
            r_dp_s2     <= 1'b0;
            r_dm_s1     <= 1'b0;
            r_dm_s2     <= 1'b0;
            r_ls_prev   <= LS_SE0;
            r_nrzi_prev <= LS_SE0;
            r_phase     <= '0;
            r_state     <= ST_WAIT_IDLE;
            r_idle_cnt  <= '0;
            r_sync_cnt  <= 3'd0;
            r_ones      <= 3'd0;
            r_bcnt      <= 3'd0;
            r_se0_cnt   <= 2'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_err       <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_dp_s1     <= USB_DP;
            r_dp_s2     <= r_dp_s1;
            r_dm_s1     <= USB_DM;
            r_dm_s2     <= r_dm_s1;
            r_ls_prev   <= w_ls;
            r_nrzi_prev <= w_nrzi_nxt;
            r_phase     <= (w_ls_change || r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
            r_state     <= w_state_nxt;
            r_idle_cnt  <= w_idle_cnt_nxt;
            r_sync_cnt  <= w_sync_cnt_nxt;
            r_ones      <= w_ones_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_se0_cnt   <= w_se0_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_start     <= w_start_nxt;
            r_end       <= w_end_nxt;
            r_err       <= w_err_nxt;
            r_active    <= w_active_nxt;
        end
    end

`ifdef USB_RX_PID_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RESET) r_first <= 1'b0;
        else       r_first <= w_first_nxt;
    end
`endif

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_pkt_start = r_start;
    assign rx_pkt_end   = r_end;
    assign rx_err       = r_err;
    assign rx_active    = r_active;
endmodule
